// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states, requester ids
// and the latency counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

    typedef enum logic {REQ_I, REQ_D} req_id_t;

    localparam int unsigned LAT_W = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selector for the memory-port arbiter.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise D has fixed priority over I.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic    if_req,
    input  logic    dm_req,
    input  req_id_t last_grant,
    output req_id_t grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        grant = REQ_I;
        if (if_req && dm_req) begin
            // On a tie, hand the port to whoever did not have it last.
            grant = (last_grant == REQ_D) ? REQ_I : REQ_D;
        end else if (dm_req) begin
            grant = REQ_D;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign grant = dm_req ? REQ_D : REQ_I;
    logic unused_if_req;
    assign unused_if_req = if_req;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch (I) and data access (D).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; default is D-over-I priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_d
);

    localparam logic [LAT_W-1:0] RD_WAIT = LAT_W'(MEM_LAT - 1);

    arb_state_t        state_q, state_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    req_id_t           grant_q;
    req_id_t           pick;
    req_id_t           last_grant;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_wr_q;
    logic              word_hi_q;
    logic              start;

    logic unused_if_addr;
    assign unused_if_addr = ^if_addr[1:0];

    assign start = (state_q == IDLE) && (if_req || dm_req);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    req_id_t last_q;

    // Reset to D so the first tie after reset goes to I.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= REQ_D;
        end else if (start) begin
            last_q <= pick;
        end
    end

    assign last_grant = last_q;
`else
    assign last_grant = grant_q;
`endif

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .dm_req     (dm_req),
        .last_grant (last_grant),
        .grant      (pick)
    );

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // mem_wr_q is high here exactly when this is a store.
                lat_cnt_d = mem_wr_q ? '0 : RD_WAIT;
                state_d   = (mem_wr_q || (RD_WAIT == '0)) ? RESP : WAIT;
            end
            WAIT: begin
                lat_cnt_d = lat_cnt_q - 1'b1;
                if (lat_cnt_q <= LAT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q     <= REQ_I;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_q    <= 1'b0;
            word_hi_q   <= 1'b0;
        end else begin
            mem_wr_q <= 1'b0;
            if (start) begin
                grant_q   <= pick;
                word_hi_q <= if_addr[2];
                if (pick == REQ_D) begin
                    mem_addr_q  <= dm_addr;
                    mem_wdata_q <= dm_wdata;
                    mem_wr_q    <= dm_we;
                end else begin
                    mem_addr_q  <= {if_addr[ADDR_W-1:3], 3'b000};
                    mem_wdata_q <= '0;
                end
            end
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wr    = mem_wr_q;
    assign busy      = (state_q != IDLE);
    assign grant_d   = (grant_q == REQ_D);
    assign if_ack    = (state_q == RESP) && (grant_q == REQ_I);
    assign dm_ack    = (state_q == RESP) && (grant_q == REQ_D);
    assign if_rdata  = if_ack ? (word_hi_q ? mem_rdata[63:32] : mem_rdata[31:0]) : '0;
    assign dm_rdata  = dm_ack ? mem_rdata : '0;

`ifndef SYNTHESIS
    // The granted requester must hold its request until it sees the ack.
    always_ff @(posedge clk) begin
        if (!rst && (state_q != IDLE)) begin
            assert ((grant_q == REQ_D) ? dm_req : if_req)
                else $warning("mem_port_arbiter: request dropped before ack");
        end
    end
`endif

endmodule
